// File: rtl/rggen_irq_coalescer_if.sv
// Bundle between the interrupt coalescer and its status field, event sources and the irq consumer.
// Signal names keep the field-side i_/o_ view so they line up with the rggen bit field ports.
interface rggen_irq_coalescer_if #(
    parameter int WIDTH         = 8,
    parameter int COUNT_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
);
    logic [WIDTH-1:0]         i_event;
    logic [WIDTH-1:0]         o_set;
    logic [WIDTH-1:0]         i_status;
    logic [WIDTH-1:0]         i_enable;
    logic [COUNT_WIDTH-1:0]   i_threshold;
    logic [TIMEOUT_WIDTH-1:0] i_timeout;
    logic                     o_irq;
    logic                     i_irq_ack;
    logic                     o_busy;
    logic [1:0]               dbg_state;

    // Handshake: o_irq acts as valid and stays high until a single-cycle i_irq_ack (ready) is seen
    // while it is high; o_irq drops the following cycle. An ack with o_irq low is ignored.
    modport master (
        output i_event, i_status, i_enable, i_threshold, i_timeout, i_irq_ack,
        input  o_set, o_irq, o_busy, dbg_state
    );

    modport slave (
        input  i_event, i_status, i_enable, i_threshold, i_timeout, i_irq_ack,
        output o_set, o_irq, o_busy, dbg_state
    );
endinterface

// File: rtl/rggen_irq_coalescer.sv
// Coalesces hardware events into one interrupt by count threshold or timeout, then waits for SW clear.
// Optional macro RGGEN_IRQ_EVENT_EDGE_EN: treat i_event as levels and use only their rising edges.
module rggen_irq_coalescer #(
    parameter int WIDTH         = 8,
    parameter int COUNT_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    rggen_irq_coalescer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCUM      = 2'd1,
        ASSERT     = 2'd2,
        WAIT_CLEAR = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]   COUNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_ONE = TIMEOUT_WIDTH'(1);

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   count;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic                     irq_q;
    logic                     busy_q;

    logic [WIDTH-1:0]         ev;
    logic                     hit;
    logic                     pending;
    logic [COUNT_WIDTH-1:0]   thr_eff;
    logic [COUNT_WIDTH-1:0]   count_next;
    logic [TIMEOUT_WIDTH-1:0] timer_inc;
    logic                     timeout_hit;

`ifdef RGGEN_IRQ_EVENT_EDGE_EN
    logic [WIDTH-1:0] event_q;

    // event_q resets to 0 so a level already high when reset releases still counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= bus.i_event;
        end
    end

    assign ev = bus.i_event & ~event_q;
`else
    assign ev = bus.i_event;
`endif

    assign bus.o_set     = ev;
    assign hit           = |(ev & bus.i_enable);
    assign pending       = |(bus.i_status & bus.i_enable);
    assign thr_eff       = (bus.i_threshold == '0) ? COUNT_ONE : bus.i_threshold;
    assign count_next    = (hit && !(&count)) ? count + COUNT_ONE : count;
    assign timer_inc     = (&timer) ? timer : timer + TIMEOUT_ONE;
    // Timer holds ACCUM cycles already elapsed, so firing at i_timeout-1 raises irq i_timeout+1 after the first hit.
    assign timeout_hit   = (bus.i_timeout != '0) && (timer == bus.i_timeout - TIMEOUT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            timer  <= '0;
            irq_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE, WAIT_CLEAR: begin
                    if (hit) begin
                        count  <= COUNT_ONE;
                        timer  <= '0;
                        busy_q <= 1'b1;
                        if (thr_eff == COUNT_ONE) begin
                            state <= ASSERT;
                            irq_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end else if (state == WAIT_CLEAR && !pending) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    timer <= timer_inc;
                    count <= count_next;
                    // SW clearing everything before the irq fires cancels the batch ahead of any timeout.
                    if (!pending && !hit) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (count_next >= thr_eff || timeout_hit) begin
                        state <= ASSERT;
                        irq_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (bus.i_irq_ack) begin
                        state <= WAIT_CLEAR;
                        irq_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    irq_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_irq     = irq_q;
    assign bus.o_busy    = busy_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: directed scenarios plus random traffic against a cycle-level reference model.
// Builds with or without RGGEN_IRQ_EVENT_EDGE_EN; the model follows the same macro.
module tb_rggen_irq_coalescer;
    localparam int W    = 8;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;
    localparam int P_IDLE   = 0;
    localparam int P_ACCUM  = 1;
    localparam int P_ASSERT = 2;
    localparam int P_WAIT   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rggen_irq_coalescer_if #(.WIDTH(W), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) bus ();

    rggen_irq_coalescer #(.WIDTH(W), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Status field model: W1C with set priority over a same-cycle clear.
    logic [W-1:0] status;
    logic [W-1:0] sw_clr;
    assign bus.i_status = status;

    int n_tests = 0;
    int n_fail  = 0;

    int           m_phase;
    int           m_cnt;
    int           m_age;
    logic [W-1:0] m_prev;
    logic [W-1:0] last_set;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_ev();
`ifdef RGGEN_IRQ_EVENT_EDGE_EN
        return bus.i_event & ~m_prev;
`else
        return bus.i_event;
`endif
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_cnt   = 0;
        m_age   = 0;
        m_prev  = '0;
        status  = '0;
    endtask

    task automatic drive(input logic [W-1:0] ev, input logic [W-1:0] clr, input logic ack);
        bus.i_event   = ev;
        sw_clr        = clr;
        bus.i_irq_ack = ack;
    endtask

    // One clock: check o_set mid-cycle, predict next phase, commit after the edge, check registered outputs.
    task automatic cycle(input string tag);
        logic [W-1:0] ev;
        bit           hit;
        bit           pend;
        int           thr;
        int           nphase;
        int           ncnt;
        int           nage;
        @(negedge clk);
        ev = model_ev();
        exp_q.push_back(ev);
        last_set = bus.o_set;
        check({tag, "_set"}, 32'(bus.o_set), 32'(exp_q.pop_front()));
        hit    = |(ev & bus.i_enable);
        pend   = |(status & bus.i_enable);
        thr    = (bus.i_threshold == '0) ? 1 : int'(bus.i_threshold);
        nphase = m_phase;
        ncnt   = m_cnt;
        nage   = m_age;
        case (m_phase)
            P_IDLE, P_WAIT: begin
                if (hit) begin
                    ncnt   = 1;
                    nage   = 0;
                    nphase = (thr <= 1) ? P_ASSERT : P_ACCUM;
                end else if (m_phase == P_WAIT && !pend) begin
                    nphase = P_IDLE;
                end
            end
            P_ACCUM: begin
                nage = (m_age < TMAX) ? m_age + 1 : TMAX;
                if (hit) ncnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                if (!pend && !hit) nphase = P_IDLE;
                else if (ncnt >= thr || (bus.i_timeout != '0 && m_age == int'(bus.i_timeout) - 1))
                    nphase = P_ASSERT;
            end
            P_ASSERT: begin
                if (bus.i_irq_ack) nphase = P_WAIT;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        status  = (status & ~sw_clr) | ev;
        m_prev  = bus.i_event;
        m_phase = nphase;
        m_cnt   = ncnt;
        m_age   = nage;
        check({tag, "_irq"}, 32'(bus.o_irq), 32'(m_phase == P_ASSERT));
        check({tag, "_busy"}, 32'(bus.o_busy), 32'(m_phase != P_IDLE));
    endtask

    // Acknowledge, clear every status bit and let the block settle back to IDLE.
    task automatic finish_irq(input string tag);
        drive('0, '0, 1'b1);
        cycle({tag, "_ack"});
        drive('0, '1, 1'b0);
        cycle({tag, "_clr"});
        drive('0, '0, 1'b0);
        cycle({tag, "_idle"});
        cycle({tag, "_idle2"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pulses;
        model_reset();
        drive('0, '0, 1'b0);
        bus.i_enable    = '1;
        bus.i_threshold = CW'(1);
        bus.i_timeout   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", 32'(bus.o_irq), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;

        // Threshold 1: immediate irq, ack, W1C back to idle.
        drive(8'h04, '0, 1'b0);
        #1;
        check("t1_set_comb", 32'(bus.o_set), 32'h04);
        cycle("t1_ev");
        check("t1_irq_next", 32'(bus.o_irq), 32'd1);
        drive('0, '0, 1'b1);
        cycle("t1_ack");
        check("t1_irq_drop", 32'(bus.o_irq), 32'd0);
        drive('0, 8'h04, 1'b0);
        cycle("t1_w1c");
        drive('0, '0, 1'b0);
        cycle("t1_settle");
        check("t1_busy_idle", 32'(bus.o_busy), 32'd0);

        // Threshold 3 with hits on cycles 0, 2 and 5.
        bus.i_threshold = CW'(3);
        for (int i = 0; i < 7; i++) begin
            drive((i == 0 || i == 2 || i == 5) ? 8'h01 : 8'h00, '0, 1'b0);
            cycle("t2");
            check("t2_irq_time", 32'(bus.o_irq), 32'(i >= 5));
        end
        finish_irq("t2");

        // Timeout 10 with an unreachable threshold.
        bus.i_threshold = CW'(200);
        bus.i_timeout   = TW'(10);
        for (int i = 0; i < 14; i++) begin
            drive((i == 0) ? 8'h01 : 8'h00, '0, 1'b0);
            cycle("t3");
            check("t3_irq_time", 32'(bus.o_irq), 32'(i >= 10));
        end
        drive('0, '0, 1'b1);
        cycle("t3_ack");
        check("t3_irq_fall", 32'(bus.o_irq), 32'd0);
        finish_irq("t3");

        // Disabled bit still reaches the field but does not start a batch.
        bus.i_enable  = 8'h01;
        bus.i_timeout = '0;
        drive(8'h02, '0, 1'b0);
        cycle("t4");
        check("t4_set", 32'(last_set), 32'h02);
        check("t4_busy", 32'(bus.o_busy), 32'd0);
        drive('0, '1, 1'b0);
        cycle("t4_clr");
        bus.i_enable = '1;

        // Re-arm from WAIT_CLEAR on a hit that coincides with SW clearing everything.
        bus.i_threshold = CW'(2);
        drive(8'h01, '0, 1'b0);
        cycle("t5_h1");
        drive(8'h02, '0, 1'b0);
        cycle("t5_h2");
        check("t5_irq1", 32'(bus.o_irq), 32'd1);
        drive('0, '0, 1'b1);
        cycle("t5_ack");
        drive(8'h01, '1, 1'b0);
        cycle("t5_rearm");
        check("t5_busy_rearm", 32'(bus.o_busy), 32'd1);
        check("t5_irq_rearm", 32'(bus.o_irq), 32'd0);
        drive(8'h02, '0, 1'b0);
        cycle("t5_h3");
        check("t5_irq2", 32'(bus.o_irq), 32'd1);
        finish_irq("t5");

        // Asynchronous reset while irq is high, then a held level through reset release.
        bus.i_threshold = CW'(1);
        drive(8'h01, '0, 1'b0);
        cycle("t6_ev");
        check("t6_irq_before", 32'(bus.o_irq), 32'd1);
        drive('0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_irq_async", 32'(bus.o_irq), 32'd0);
        check("t6_busy_async", 32'(bus.o_busy), 32'd0);
        model_reset();
        bus.i_threshold = CW'(5);
        drive(8'h01, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("t6_level");
            if (last_set[0]) n_pulses++;
        end
`ifdef RGGEN_IRQ_EVENT_EDGE_EN
        check("t6_pulse_count", 32'(n_pulses), 32'd1);
`else
        check("t6_pulse_count", 32'(n_pulses), 32'd5);
`endif
        drive('0, '0, 1'b0);
        cycle("t6_release");
        for (int i = 0; i < 12; i++) cycle("t6_drain");
        if (m_phase == P_ASSERT) finish_irq("t6");
        drive('0, '1, 1'b0);
        cycle("t6_clr");

        // Random traffic with live changes to enable, threshold and timeout.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bus.i_threshold = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) bus.i_timeout   = TW'($urandom_range(0, 8));
            if ($urandom_range(0, 31) == 0) bus.i_enable    = W'($urandom);
            drive(($urandom_range(0, 2) == 0) ? W'($urandom) : '0,
                  (m_phase == P_WAIT || $urandom_range(0, 9) == 0) ? W'($urandom) : '0,
                  ($urandom_range(0, 3) == 0));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
